// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the card-matching turn controller.
package memory_game_pkg;

  typedef enum logic [1:0] {
    PICK1 = 2'd0,
    PICK2 = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Player index width: max(1, clog2(n)).
  function automatic int pw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int score_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/memory_game_ctrl_turn_timer.sv
// Per-pick window counter; expire pulses at TURN_TIMEOUT-1 and the count restarts.
module turn_timer #(
  parameter int TURN_TIMEOUT = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TURN_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expire = enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear || expire) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_game_ctrl.sv
// Turn controller: pairs up card picks, keeps scores, rotates players and
// forfeits turns whose pick window expires. All outputs are registered.
module memory_game_ctrl
  import memory_game_pkg::*;
#(
  parameter int CARD_W       = 4,
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_PAIRS    = 8,
  parameter int SCORE_W      = 4,
  parameter int TURN_TIMEOUT = 50_000_000,
  localparam int PW          = pw_of(NUM_PLAYERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           card_valid,
  input  logic [CARD_W-1:0]              card_value,
  output logic [PW-1:0]                  player,
  output logic                           match,
  output logic                           mismatch,
  output logic                           timeout,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           game_over,
  output logic [PW-1:0]                  winner,
  output state_e                         state_dbg
);

  localparam int PFW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS + 1) : 1;

  state_e                         state_q, state_d;
  logic [CARD_W-1:0]              held_q, held_d;
  logic [PW-1:0]                  player_q, player_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
  logic [PFW-1:0]                 pairs_q, pairs_d;
  logic                           match_q, match_d;
  logic                           mismatch_q, mismatch_d;
  logic                           timeout_q, timeout_d;
  logic                           game_over_q, game_over_d;
  logic [PW-1:0]                  winner_q, winner_d;

  logic               expire;
  logic               tmr_enable;
  logic               tmr_clear;
  logic               same_card;
  logic               last_pair;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] best_score;
  logic [PW-1:0]      best_idx;

  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    return (p == PW'(NUM_PLAYERS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign tmr_enable = (state_q == PICK1) || (state_q == PICK2);
  assign tmr_clear  = tmr_enable && card_valid;
  assign same_card  = (card_value == held_q);
  assign last_pair  = (pairs_q == PFW'(NUM_PAIRS - 1));

  turn_timer #(
    .TURN_TIMEOUT(TURN_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .enable(tmr_enable),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= PICK1;
      held_q      <= '0;
      player_q    <= '0;
      scores_q    <= '0;
      pairs_q     <= '0;
      match_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      player_q    <= player_d;
      scores_q    <= scores_d;
      pairs_q     <= pairs_d;
      match_q     <= match_d;
      mismatch_q  <= mismatch_d;
      timeout_q   <= timeout_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  // A card arriving on the expiry cycle takes precedence over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PICK1: begin
        if (card_valid) state_d = PICK2;
      end
      PICK2: begin
        if (card_valid) begin
          state_d = (same_card && last_pair) ? DONE : PICK1;
        end else if (expire) begin
          state_d = PICK1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = PICK1;
    endcase
  end

  always_comb begin
    held_d     = held_q;
    player_d   = player_q;
    scores_d   = scores_q;
    pairs_d    = pairs_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    timeout_d  = 1'b0;
    cur_score  = scores_q[score_lsb(int'(player_q), SCORE_W) +: SCORE_W];
    case (state_q)
      PICK1: begin
        if (card_valid) begin
          held_d = card_value;
        end else if (expire) begin
          timeout_d = 1'b1;
          player_d  = next_player(player_q);
        end
      end
      PICK2: begin
        if (card_valid && same_card) begin
          match_d = 1'b1;
          pairs_d = pairs_q + PFW'(1);
          if (cur_score != '1) begin
            scores_d[score_lsb(int'(player_q), SCORE_W) +: SCORE_W] = cur_score + SCORE_W'(1);
          end
        end else if (card_valid) begin
          mismatch_d = 1'b1;
          player_d   = next_player(player_q);
        end else if (expire) begin
          timeout_d = 1'b1;
          held_d    = '0;
          player_d  = next_player(player_q);
        end
      end
      default: ;
    endcase

    // Argmax over the updated scores; strict compare keeps the lowest index on ties.
    best_score = scores_d[SCORE_W-1:0];
    best_idx   = '0;
    for (int k = 1; k < NUM_PLAYERS; k++) begin
      if (scores_d[score_lsb(k, SCORE_W) +: SCORE_W] > best_score) begin
        best_score = scores_d[score_lsb(k, SCORE_W) +: SCORE_W];
        best_idx   = PW'(k);
      end
    end

    game_over_d = (state_d == DONE);
    winner_d    = ((state_d == DONE) && (state_q != DONE)) ? best_idx : winner_q;
  end

  assign player    = player_q;
  assign match     = match_q;
  assign mismatch  = mismatch_q;
  assign timeout   = timeout_q;
  assign scores    = scores_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Bench for memory_game_ctrl: vector table, directed corner sequences and a
// randomized run, all scored against a turn-level model of the game rules.
module tb_memory_game_ctrl;
  import memory_game_pkg::*;

  localparam int CW  = 4;
  localparam int NP  = 3;
  localparam int NPR = 2;
  localparam int TO  = 16;
  localparam int SW  = 4;
  localparam int PW  = 2;
  localparam int VW  = 3 + PW + NP * SW + 1 + PW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              card_valid = 1'b0;
  logic [CW-1:0]     card_value = '0;
  logic [PW-1:0]     player;
  logic              match;
  logic              mismatch;
  logic              timeout;
  logic [NP*SW-1:0]  scores;
  logic              game_over;
  logic [PW-1:0]     winner;
  state_e            state_dbg;

  memory_game_ctrl #(
    .CARD_W(CW), .NUM_PLAYERS(NP), .NUM_PAIRS(NPR), .SCORE_W(SW), .TURN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_value(card_value),
    .player(player), .match(match), .mismatch(mismatch), .timeout(timeout),
    .scores(scores), .game_over(game_over), .winner(winner), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [VW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (turn-level game rules) ----------------
  int m_player, m_pairs, m_idle, m_first, m_winner;
  int m_score[NP];
  bit m_have_first, m_over, m_match, m_mis, m_to;

  function automatic void model_reset();
    m_player = 0; m_pairs = 0; m_idle = 0; m_first = 0; m_winner = 0;
    for (int k = 0; k < NP; k++) m_score[k] = 0;
    m_have_first = 0; m_over = 0; m_match = 0; m_mis = 0; m_to = 0;
  endfunction

  function automatic void model_step(input bit rn, input bit v, input int val);
    m_match = 0; m_mis = 0; m_to = 0;
    if (!rn) begin
      model_reset();
    end else if (!m_over) begin
      if (v) begin
        m_idle = 0;
        if (!m_have_first) begin
          m_have_first = 1;
          m_first = val;
        end else begin
          m_have_first = 0;
          if (val == m_first) begin
            m_match = 1;
            if (m_score[m_player] < (1 << SW) - 1) m_score[m_player]++;
            m_pairs++;
            if (m_pairs == NPR) begin
              m_over = 1;
              m_winner = 0;
              for (int k = 1; k < NP; k++)
                if (m_score[k] > m_score[m_winner]) m_winner = k;
            end
          end else begin
            m_mis = 1;
            m_player = (m_player + 1) % NP;
          end
        end
      end else if (m_idle == TO - 1) begin
        m_to = 1;
        m_idle = 0;
        m_have_first = 0;
        m_player = (m_player + 1) % NP;
      end else begin
        m_idle++;
      end
    end
  endfunction

  function automatic logic [VW-1:0] model_pack();
    logic [NP*SW-1:0] sc;
    sc = '0;
    for (int k = 0; k < NP; k++) sc[k*SW +: SW] = SW'(m_score[k]);
    return {m_match, m_mis, m_to, PW'(m_player), sc, m_over, PW'(m_winner)};
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input bit rn, input bit v, input logic [CW-1:0] val);
    logic [VW-1:0] got;
    rst = rn; card_valid = v; card_value = val;
    model_step(rn, v, int'(val));
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    got = {match, mismatch, timeout, player, scores, game_over, winner};
    check("model", 32'(got), 32'(exp_q.pop_front()));
    card_valid = 1'b0;
  endtask

  task automatic pick(input logic [CW-1:0] val);
    tick(1, 0, '0);
    tick(1, 1, val);
  endtask

  task automatic do_reset();
    tick(0, 0, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            rn;
    bit            v;
    logic [CW-1:0] val;
    bit            e_m;
    bit            e_mm;
    bit            e_to;
    logic [PW-1:0] e_pl;
    logic [NP*SW-1:0] e_sc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int first_to;
    bit saw_pulse;
    bit prev_v;
    int rate;

    vecs[0] = '{0, 0, 4'd0, 0, 0, 0, 2'd0, 12'h000};
    vecs[1] = '{1, 1, 4'd5, 0, 0, 0, 2'd0, 12'h000};
    vecs[2] = '{1, 1, 4'd5, 1, 0, 0, 2'd0, 12'h001};
    vecs[3] = '{1, 1, 4'd3, 0, 0, 0, 2'd0, 12'h001};
    vecs[4] = '{1, 1, 4'd7, 0, 1, 0, 2'd1, 12'h001};
    vecs[5] = '{1, 1, 4'd1, 0, 0, 0, 2'd1, 12'h001};
    vecs[6] = '{1, 1, 4'd2, 0, 1, 0, 2'd2, 12'h001};
    vecs[7] = '{1, 1, 4'd8, 0, 0, 0, 2'd2, 12'h001};
    vecs[8] = '{1, 1, 4'd9, 0, 1, 0, 2'd0, 12'h001};
    vecs[9] = '{1, 0, 4'd0, 0, 0, 0, 2'd0, 12'h001};

    model_reset();

    // Matches, mismatches and player wrap from the table.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].v) tick(1, 0, '0);
      tick(vecs[i].rn, vecs[i].v, vecs[i].val);
      check($sformatf("vec%0d_match", i),    32'(match),     32'(vecs[i].e_m));
      check($sformatf("vec%0d_mismatch", i), 32'(mismatch),  32'(vecs[i].e_mm));
      check($sformatf("vec%0d_timeout", i),  32'(timeout),   32'(vecs[i].e_to));
      check($sformatf("vec%0d_player", i),   32'(player),    32'(vecs[i].e_pl));
      check($sformatf("vec%0d_scores", i),   32'(scores),    32'(vecs[i].e_sc));
      check($sformatf("vec%0d_game_over", i), 32'(game_over), 32'(0));
    end

    // Idle timeout in PICK1 lands on the 16th cycle.
    do_reset();
    first_to = 0;
    for (int i = 1; i <= 40 && first_to == 0; i++) begin
      tick(1, 0, '0);
      if (timeout) first_to = i;
    end
    check("pick1_timeout_cycle", 32'(first_to), 32'(16));
    check("pick1_timeout_player", 32'(player), 32'(1));
    check("pick1_timeout_scores", 32'(scores), 32'(0));

    // Timeout in PICK2 drops the held card.
    do_reset();
    pick(4'd9);
    first_to = 0;
    for (int i = 1; i <= 16; i++) begin
      tick(1, 0, '0);
      if (timeout && first_to == 0) first_to = i;
    end
    check("pick2_timeout_cycle", 32'(first_to), 32'(16));
    check("pick2_timeout_player", 32'(player), 32'(1));
    pick(4'd4);
    check("after_to_first_pick_nomis", 32'(mismatch), 32'(0));
    pick(4'd4);
    check("after_to_match", 32'(match), 32'(1));
    check("after_to_scores", 32'(scores), 32'(12'h010));

    // Card on the expiry cycle wins over the timeout.
    for (int i = 0; i < TO - 1; i++) tick(1, 0, '0);
    tick(1, 1, 4'd2);
    check("coincide_no_timeout", 32'(timeout), 32'(0));
    check("coincide_player", 32'(player), 32'(1));
    pick(4'd2);
    check("coincide_pick_accepted", 32'(match), 32'(1));

    // Final pair with a 1-1 tie: winner is the lower index.
    do_reset();
    pick(4'd1); pick(4'd2);
    pick(4'd4); pick(4'd4);
    pick(4'd1); pick(4'd2);
    pick(4'd6); pick(4'd6);
    check("final_match", 32'(match), 32'(1));
    check("final_game_over", 32'(game_over), 32'(1));
    check("final_winner", 32'(winner), 32'(1));
    saw_pulse = 0;
    pick(4'd6); saw_pulse |= match | mismatch | timeout;
    pick(4'd6); saw_pulse |= match | mismatch | timeout;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, '0);
      saw_pulse |= match | mismatch | timeout;
    end
    check("done_no_pulses", 32'(saw_pulse), 32'(0));
    check("done_scores_frozen", 32'(scores), 32'(12'h110));
    check("done_game_over_held", 32'(game_over), 32'(1));
    check("done_winner_held", 32'(winner), 32'(1));

    // Reset mid-turn discards the held card and scores.
    do_reset();
    pick(4'd2); pick(4'd2);
    pick(4'd3);
    do_reset();
    check("midreset_scores", 32'(scores), 32'(0));
    check("midreset_player", 32'(player), 32'(0));
    check("midreset_pulses", 32'({match, mismatch, timeout, game_over}), 32'(0));
    pick(4'd7);
    check("midreset_first_pick", 32'(mismatch), 32'(0));
    pick(4'd7);
    check("midreset_match", 32'(match), 32'(1));
    check("midreset_score0", 32'(scores), 32'(12'h001));
    check("midreset_player0", 32'(player), 32'(0));

    // Randomized play against the model; rate alternates to provoke timeouts.
    do_reset();
    prev_v = 0;
    for (int i = 0; i < 1200; i++) begin
      bit rn;
      bit v;
      rate = ((i / 100) % 2 == 0) ? 40 : 3;
      rn = ($urandom_range(0, 79) != 0);
      v = !prev_v && ($urandom_range(0, 99) < rate);
      tick(rn, v, CW'($urandom_range(0, 3)));
      prev_v = v;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
